// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external 8-bit ALU to multiply by repeated addition and divide by repeated subtraction
module alu_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             ovf,
   output logic             div_zero,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [WIDTH-1:0] alu_in3,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out
);
   typedef enum logic [2:0] {IDLE, LOAD, MUL_STEP, DIV_STEP, FINISH} state_t;
   state_t state;
   logic [WIDTH-1:0] a_r, b_r, acc, cnt;
   logic mode_r;
   always_comb begin
      alu_op  = state == MUL_STEP ? 2'd1 : state == DIV_STEP ? 2'd2 : 2'd0;
      alu_in1 = state == LOAD ? (mode_r ? a_r : '0) :
                (state == MUL_STEP || state == DIV_STEP) ? acc : '0;
      alu_in2 = state == DIV_STEP ? b_r : '0;
      alu_in3 = state == MUL_STEP ? a_r : '0;
   end
   // the ALU result returns in the same cycle, so every step commits alu_out directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         div_zero  <= 1'b0;
         result    <= '0;
         remainder <= '0;
         a_r       <= '0;
         b_r       <= '0;
         mode_r    <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r      <= operand_a;
               b_r      <= operand_b;
               mode_r   <= mode;
               ovf      <= 1'b0;
               div_zero <= 1'b0;
               busy     <= 1'b1;
               state    <= LOAD;
            end
            LOAD: if (!mode_r) begin
               acc   <= alu_out;
               cnt   <= b_r;
               state <= MUL_STEP;
            end else if (b_r != '0) begin
               acc   <= alu_out;
               cnt   <= '0;
               state <= DIV_STEP;
            end else begin
               div_zero  <= 1'b1;
               result    <= '1;
               remainder <= a_r;
               done      <= 1'b1;
               state     <= FINISH;
            end
            MUL_STEP: if (cnt == '0) begin
               result    <= acc;
               remainder <= '0;
               done      <= 1'b1;
               state     <= FINISH;
            end else begin
               acc <= alu_out;
               cnt <= cnt - 1'b1;
               if (alu_out < acc) ovf <= 1'b1;
            end
            DIV_STEP: if (acc < b_r) begin
               result    <= cnt;
               remainder <= acc;
               done      <= 1'b1;
               state     <= FINISH;
            end else begin
               acc <= alu_out;
               cnt <= cnt + 1'b1;
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed multiply/divide vectors against alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
   logic [7:0] operand_a = '0, operand_b = '0;
   logic busy, done, ovf, div_zero;
   logic [7:0] result, remainder, alu_in1, alu_in2, alu_in3, alu_out;
   logic [1:0] alu_op;
   int checks = 0, failures = 0, edges = 0;
   logic seen_done;

   always #5 clk = ~clk;

   assign alu_out = alu_op == 2'd1 ? alu_in1 + alu_in3 :
                    alu_op == 2'd2 ? alu_in1 - alu_in2 : alu_in1;

   alu_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .result(result), .remainder(remainder),
      .ovf(ovf), .div_zero(div_zero),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3),
      .alu_op(alu_op), .alu_out(alu_out)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic go(input logic m, input logic [7:0] a, input logic [7:0] b);
      start = 1'b1;
      mode = m;
      operand_a = a;
      operand_b = b;
      @(posedge clk);
      #1;
      edges = 0;
      start = 1'b0;
      operand_a = 8'hAA;
      operand_b = 8'h55;
   endtask

   task automatic wait_done(input string tag, input int exp_e, input int res, input int rem,
                            input int o, input int dz);
      while (!done && edges < 400) tick();
      chk({tag, "_edge"}, edges, exp_e);
      chk({tag, "_result"}, result, res);
      chk({tag, "_rem"}, remainder, rem);
      chk({tag, "_ovf"}, ovf, o);
      chk({tag, "_dz"}, div_zero, dz);
      chk({tag, "_busy_fin"}, busy, 1);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_low"}, busy, 0);
   endtask

   initial begin
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_aluop", alu_op, 0);
      rst = 1'b0;
      tick();

      go(1'b0, 8'd7, 8'd6);
      chk("mul7x6_busy", busy, 1);
      chk("mul7x6_load_in1", alu_in1, 0);
      tick();
      chk("mul7x6_aluop", alu_op, 1);
      chk("mul7x6_in3", alu_in3, 7);
      tick();
      chk("mul7x6_aluop2", alu_op, 1);
      wait_done("mul7x6", 8, 42, 0, 0, 0);

      go(1'b0, 8'd20, 8'd13);
      wait_done("mul20x13", 15, 4, 0, 1, 0);
      go(1'b0, 8'd5, 8'd0);
      wait_done("mul5x0", 2, 0, 0, 0, 0);

      go(1'b1, 8'd100, 8'd7);
      chk("div100_load_in1", alu_in1, 100);
      tick();
      chk("div100_aluop", alu_op, 2);
      chk("div100_in2", alu_in2, 7);
      wait_done("div100by7", 16, 14, 2, 0, 0);
      go(1'b1, 8'd3, 8'd9);
      wait_done("div3by9", 2, 0, 3, 0, 0);

      go(1'b1, 8'd77, 8'd0);
      tick();
      chk("div0_edge_done", done, 1);
      chk("div0_dz", div_zero, 1);
      chk("div0_result", result, 255);
      chk("div0_rem", remainder, 77);
      start = 1'b1;
      mode = 1'b0;
      tick();
      start = 1'b0;
      chk("div0_busy_e2", busy, 0);
      chk("div0_done_e2", done, 0);
      tick();
      chk("div0_start_in_finish_ignored", busy, 0);

      go(1'b1, 8'd255, 8'd1);
      tick();
      start = 1'b1;
      mode = 1'b0;
      operand_a = 8'd3;
      operand_b = 8'd3;
      repeat (3) tick();
      start = 1'b0;
      wait_done("div255by1", 257, 255, 0, 0, 0);

      go(1'b0, 8'd9, 8'd50);
      seen_done = 1'b0;
      repeat (9) begin
         tick();
         seen_done |= done;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_result", result, 0);
      chk("midrst_done", done, 0);
      repeat (3) begin
         tick();
         seen_done |= done;
      end
      rst = 1'b0;
      repeat (3) begin
         tick();
         seen_done |= done;
      end
      chk("midrst_nodone", seen_done, 0);
      chk("midrst_idle_busy", busy, 0);
      go(1'b0, 8'd3, 8'd3);
      wait_done("mul3x3", 5, 9, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
